// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice: widths, the unmapped
// word address and the response-owner encoding.
package dmem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] DMEM_UNMAPPED = 8'hFF;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on conflict, or A-always-wins when FIXED_PRIO
// is non-zero. Grants are combinational and held off during reset.
module rr_arb2
    import dmem_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    owner_t last_q;
    owner_t last_d;

    always_comb begin
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        last_d = last_q;
        if (!rst) begin
            if (req_a && req_b) begin
                if ((FIXED_PRIO != 0) || (last_q == OWN_B)) begin
                    gnt_a = 1'b1;
                end else begin
                    gnt_b = 1'b1;
                end
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
            // Pointer only moves on an actual grant; idle cycles keep it.
            if (gnt_a) begin
                last_d = OWN_A;
            end else if (gnt_b) begin
                last_d = OWN_B;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port 16x256 data memory between port A (LSU) and port B
// (DMA/debug), screening the unmapped word and routing read data back.
module data_mem_arbiter
    import dmem_pkg::*;
#(
    parameter int                FIXED_PRIO    = 0,
    parameter logic [ADDR_W-1:0] UNMAPPED_ADDR = DMEM_UNMAPPED
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wd,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rd,
    output logic              a_err,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wd,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rd,
    output logic              b_err,

    output logic [ADDR_W-1:0] mem_rwa,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    logic              sel_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wd;
    logic              sel_unmapped;

    logic   resp_valid;
    owner_t resp_owner;
    logic   resp_err;

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req_a(a_req),
        .req_b(b_req),
        .gnt_a(a_gnt),
        .gnt_b(b_gnt)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wd    = '0;
        if (a_gnt) begin
            sel_valid = 1'b1;
            sel_we    = a_we;
            sel_addr  = a_addr;
            sel_wd    = a_wd;
        end else if (b_gnt) begin
            sel_valid = 1'b1;
            sel_we    = b_we;
            sel_addr  = b_addr;
            sel_wd    = b_wd;
        end
    end

    assign sel_unmapped = sel_valid && (sel_addr == UNMAPPED_ADDR);

    assign mem_rwa = sel_addr;
    assign mem_wd  = sel_wd;
    assign mem_we  = sel_we && !sel_unmapped;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_owner <= OWN_A;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= sel_valid;
            resp_owner <= b_gnt ? OWN_B : OWN_A;
            resp_err   <= sel_unmapped;
        end
    end

    // Read data is zeroed both when idle and for unmapped accesses.
    assign a_rvalid = resp_valid && (resp_owner == OWN_A);
    assign b_rvalid = resp_valid && (resp_owner == OWN_B);
    assign a_err    = a_rvalid && resp_err;
    assign b_err    = b_rvalid && resp_err;
    assign a_rd     = (a_rvalid && !resp_err) ? mem_rd : '0;
    assign b_rd     = (b_rvalid && !resp_err) ? mem_rd : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench: instance 0 round-robin, instance 1 fixed priority, each
// with its own behavioural memory and an independent reference model.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Requests indexed [instance][port], port 0 = A, 1 = B.
    logic        pv   [2][2];
    logic        pwe  [2][2];
    logic [7:0]  paddr[2][2];
    logic [15:0] pwd  [2][2];

    logic        gnt [2][2];
    logic        rv  [2][2];
    logic        err [2][2];
    logic [15:0] rd  [2][2];

    logic [7:0]  mem_rwa[2];
    logic        mem_we [2];
    logic [15:0] mem_wd [2];
    logic [15:0] mem_rd [2];

    typedef struct {
        int          due;
        int          port;
        logic [15:0] rd;
        logic        err;
    } exp_t;

    exp_t        expq[2][$];
    logic [15:0] refm[2][256];
    int          last[2];
    bit          gr[2][2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    function automatic logic [15:0] init_val(logic [7:0] a);
        return (a == 8'h20) ? 16'h5555 : {a, ~a};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic [15:0] m [256];
        logic [15:0] q;

        data_mem_arbiter #(
            .FIXED_PRIO   (g),
            .UNMAPPED_ADDR(8'hFF)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .a_req   (pv[g][0]),
            .a_we    (pwe[g][0]),
            .a_addr  (paddr[g][0]),
            .a_wd    (pwd[g][0]),
            .a_gnt   (gnt[g][0]),
            .a_rvalid(rv[g][0]),
            .a_rd    (rd[g][0]),
            .a_err   (err[g][0]),
            .b_req   (pv[g][1]),
            .b_we    (pwe[g][1]),
            .b_addr  (paddr[g][1]),
            .b_wd    (pwd[g][1]),
            .b_gnt   (gnt[g][1]),
            .b_rvalid(rv[g][1]),
            .b_rd    (rd[g][1]),
            .b_err   (err[g][1]),
            .mem_rwa (mem_rwa[g]),
            .mem_we  (mem_we[g]),
            .mem_wd  (mem_wd[g]),
            .mem_rd  (mem_rd[g])
        );

        // Single-port memory: registered read, old data on read-during-write.
        initial begin
            for (int a = 0; a < 256; a++) m[a] = init_val(8'(a));
        end
        always @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else begin
                q <= m[mem_rwa[g]];
                if (mem_we[g]) m[mem_rwa[g]] <= mem_wd[g];
            end
        end
        assign mem_rd[g] = q;
    end

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", name, i, cyc, act, exp);
        end
    endtask

    // Monitor: compares any presented response against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (expq[i].size() > 0 && expq[i][0].due == cyc) begin
                    exp_t e;
                    e = expq[i].pop_front();
                    for (int p = 0; p < 2; p++) begin
                        chk(p == 0 ? "a_rvalid" : "b_rvalid", i, 32'(rv[i][p]), 32'(p == e.port));
                        chk(p == 0 ? "a_rd" : "b_rd", i, 32'(rd[i][p]), (p == e.port) ? 32'(e.rd) : 0);
                        chk(p == 0 ? "a_err" : "b_err", i, 32'(err[i][p]), (p == e.port) ? 32'(e.err) : 0);
                    end
                end else begin
                    for (int p = 0; p < 2; p++) begin
                        chk(p == 0 ? "a_rvalid_idle" : "b_rvalid_idle", i, 32'(rv[i][p]), 0);
                        chk(p == 0 ? "a_rd_idle" : "b_rd_idle", i, 32'(rd[i][p]), 0);
                    end
                end
            end
        end
    end

    // Reference model for one cycle: decides the winner from the rules,
    // checks grant and memory drive, and queues the expected response.
    task automatic model_cycle();
        for (int i = 0; i < 2; i++) begin
            int  w;
            bit  fixed;
            w     = -1;
            fixed = (i == 1);
            gr[i][0] = 1'b0;
            gr[i][1] = 1'b0;
            if (!rst) begin
                if (pv[i][0] && pv[i][1]) w = (fixed || last[i] == 1) ? 0 : 1;
                else if (pv[i][0]) w = 0;
                else if (pv[i][1]) w = 1;
            end
            chk("a_gnt", i, 32'(gnt[i][0]), 32'(w == 0));
            chk("b_gnt", i, 32'(gnt[i][1]), 32'(w == 1));
            if (w >= 0) begin
                logic [7:0] a;
                bit         um;
                exp_t       e;
                a  = paddr[i][w];
                um = (a == 8'hFF);
                chk("mem_rwa", i, 32'(mem_rwa[i]), 32'(a));
                chk("mem_wd", i, 32'(mem_wd[i]), 32'(pwd[i][w]));
                chk("mem_we", i, 32'(mem_we[i]), 32'(pwe[i][w] && !um));
                e.due  = cyc + 1;
                e.port = w;
                e.rd   = um ? 16'h0 : refm[i][a];
                e.err  = um;
                expq[i].push_back(e);
                if (pwe[i][w] && !um) refm[i][a] = pwd[i][w];
                last[i]  = w;
                gr[i][w] = 1'b1;
            end else begin
                chk("mem_idle", i, {mem_rwa[i], mem_we[i], 7'd0, mem_wd[i]}, 0);
            end
            if (rst) last[i] = 1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
                if (gr[i][p]) pv[i][p] = 1'b0;
    endtask

    task automatic issue(int i, int p, logic we, logic [7:0] a, logic [15:0] d);
        pv[i][p]    = 1'b1;
        pwe[i][p]   = we;
        paddr[i][p] = a;
        pwd[i][p]   = d;
    endtask

    task automatic issue_both(int p, logic we, logic [7:0] a, logic [15:0] d);
        for (int i = 0; i < 2; i++) issue(i, p, we, a, d);
    endtask

    task automatic wait_all();
        int n;
        n = 0;
        while ((pv[0][0] || pv[0][1] || pv[1][0] || pv[1][1]) && n < 40) begin
            step();
            n++;
        end
        chk("grant_timeout", 0, 32'(pv[0][0] || pv[0][1] || pv[1][0] || pv[1][1]), 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            last[i] = 1;
            for (int a = 0; a < 256; a++) refm[i][a] = init_val(8'(a));
            for (int p = 0; p < 2; p++) begin
                pv[i][p] = 1'b0; pwe[i][p] = 1'b0; paddr[i][p] = '0; pwd[i][p] = '0;
                gr[i][p] = 1'b0;
            end
        end

        rst = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;

        // Continuous contention for 4 cycles, then A backs off.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++)
                for (int p = 0; p < 2; p++)
                    if (!pv[i][p]) issue(i, p, 1'b0, 8'(8'h30 + k), 16'h0);
            step();
        end
        wait_all();

        // Write then read back on A.
        issue_both(0, 1'b1, 8'h10, 16'hBEEF);
        step();
        issue_both(0, 1'b0, 8'h10, 16'h0);
        step();
        wait_all();

        // Unmapped write/read on B, neighbour untouched.
        issue_both(1, 1'b1, 8'hFF, 16'h1234);
        wait_all();
        issue_both(1, 1'b0, 8'hFF, 16'h0);
        wait_all();
        issue_both(1, 1'b0, 8'hFE, 16'h0);
        wait_all();

        // Write ack returns pre-write contents.
        issue_both(0, 1'b1, 8'h20, 16'h0001);
        wait_all();
        issue_both(0, 1'b0, 8'h20, 16'h0);
        wait_all();

        // Reset while A requests; afterwards A wins the first conflict.
        issue_both(0, 1'b0, 8'h10, 16'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        issue_both(1, 1'b0, 8'h11, 16'h0);
        step();
        wait_all();

        // Randomised traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom % 50 == 0);
            for (int i = 0; i < 2; i++)
                for (int p = 0; p < 2; p++)
                    if (!pv[i][p] && ($urandom % 2 == 0)) begin
                        logic [7:0] a;
                        int         r;
                        r = $urandom % 8;
                        a = (r == 0) ? 8'hFF : (r == 1) ? 8'hFE : 8'(8'h40 + $urandom % 16);
                        issue(i, p, 1'($urandom % 2), a, 16'($urandom));
                    end
            step();
        end

        rst = 1'b0;
        wait_all();
        step();
        step();
        for (int i = 0; i < 2; i++) chk("drain", i, 32'(expq[i].size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
